// File: rtl/atm_session_ctrl_if.sv
//==============================================================================
// Module      : atm_session_ctrl_if
// Description : Card, PIN, admin and authenticator signals of the ATM session
//               controller, bundled with controller/environment modports.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface atm_session_ctrl_if;
    logic        card_in;
    logic [3:0]  acc_num_in;
    logic        pin_valid;
    logic [15:0] pin_in;
    logic        logout;
    logic        activity;
    logic        unlock_req;
    logic [3:0]  unlock_index;
    logic        auth_found;
    logic        auth_ok;
    logic [3:0]  auth_index;
    logic [3:0]  auth_acc_num;
    logic [15:0] auth_pin;
    logic        session_active;
    logic [3:0]  session_index;
    logic [3:0]  tries_left;
    logic        eject;
    logic        evt_not_found;
    logic        evt_bad_pin;
    logic        evt_locked;
    logic        evt_timeout;
    logic [2:0]  state_out;

    modport slave (
        input  card_in, acc_num_in, pin_valid, pin_in, logout, activity,
               unlock_req, unlock_index, auth_found, auth_ok, auth_index,
        output auth_acc_num, auth_pin, session_active, session_index,
               tries_left, eject, evt_not_found, evt_bad_pin, evt_locked,
               evt_timeout, state_out
    );

    modport master (
        output card_in, acc_num_in, pin_valid, pin_in, logout, activity,
               unlock_req, unlock_index, auth_found, auth_ok, auth_index,
        input  auth_acc_num, auth_pin, session_active, session_index,
               tries_left, eject, evt_not_found, evt_bad_pin, evt_locked,
               evt_timeout, state_out
    );
endinterface

`default_nettype wire

// File: rtl/atm_session_ctrl.sv
//==============================================================================
// Module      : atm_session_ctrl
// Description : Owns one ATM customer session: account lookup, PIN retries
//               with per-account lockout, PIN and idle timeouts, eject.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module atm_session_ctrl #(
    parameter int NUM_ACCOUNTS    = 10,
    parameter int MAX_TRIES       = 3,
    parameter int PIN_TIMEOUT     = 1000,
    parameter int SESSION_TIMEOUT = 5000
) (
    input  logic              clk,
    input  logic              rst,
    atm_session_ctrl_if.slave sif
);
    localparam int c_TMR_MAX = (PIN_TIMEOUT > SESSION_TIMEOUT) ? PIN_TIMEOUT : SESSION_TIMEOUT;
    localparam int c_TMR_W   = $clog2(c_TMR_MAX + 1);
    localparam logic [c_TMR_W-1:0] c_PIN_LAST = c_TMR_W'(PIN_TIMEOUT - 1);
    localparam logic [c_TMR_W-1:0] c_SES_LAST = c_TMR_W'(SESSION_TIMEOUT - 1);
    localparam logic [c_TMR_W-1:0] c_TMR_ONE  = c_TMR_W'(1);
    localparam logic [3:0]         c_TRIES    = 4'(MAX_TRIES);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOOKUP   = 3'd1,
        S_WAIT_PIN = 3'd2,
        S_CHECK    = 3'd3,
        S_SESSION  = 3'd4,
        S_EJECT    = 3'd5
    } state_t;

    state_t                  state_q, state_d;
    logic [c_TMR_W-1:0]      timer_q, timer_d;
    logic [3:0]              index_q, index_d;
    logic [3:0]              acc_q, acc_d;
    logic [15:0]             pin_q, pin_d;
    logic [3:0]              tries_q, tries_d;
    logic [3:0]              sess_idx_q, sess_idx_d;
    logic                    active_q, active_d;
    logic                    eject_q, eject_d;
    logic                    nf_q, nf_d;
    logic                    bp_q, bp_d;
    logic                    lk_q, lk_d;
    logic                    to_q, to_d;
    logic [NUM_ACCOUNTS-1:0] lock_q, lock_d;
    logic                    w_found_locked;
    logic                    w_lock_set;
    logic [3:0]              w_tries_dec;

    // Out-of-range authenticator indices never match a slot and read unlocked.
    always_comb begin
        w_found_locked = 1'b0;
        for (int i = 0; i < NUM_ACCOUNTS; i++) begin
            if (sif.auth_index == 4'(i)) begin
                w_found_locked = lock_q[i];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        index_d     = index_q;
        acc_d       = acc_q;
        pin_d       = pin_q;
        tries_d     = tries_q;
        nf_d        = 1'b0;
        bp_d        = 1'b0;
        lk_d        = 1'b0;
        to_d        = 1'b0;
        w_lock_set  = 1'b0;
        w_tries_dec = tries_q - 4'd1;

        case (state_q)
            S_IDLE: begin
                if (sif.card_in) begin
                    acc_d   = sif.acc_num_in;
                    pin_d   = '0;
                    tries_d = c_TRIES;
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (!sif.card_in) begin
                    state_d = S_IDLE;
                end else if (!sif.auth_found) begin
                    nf_d    = 1'b1;
                    state_d = S_EJECT;
                end else if (w_found_locked) begin
                    lk_d    = 1'b1;
                    state_d = S_EJECT;
                end else begin
                    index_d = sif.auth_index;
                    timer_d = '0;
                    state_d = S_WAIT_PIN;
                end
            end
            S_WAIT_PIN: begin
                if (!sif.card_in) begin
                    state_d = S_IDLE;
                end else if (sif.pin_valid) begin
                    pin_d   = sif.pin_in;
                    state_d = S_CHECK;
                end else if (timer_q == c_PIN_LAST) begin
                    to_d    = 1'b1;
                    state_d = S_EJECT;
                end else begin
                    timer_d = timer_q + c_TMR_ONE;
                end
            end
            S_CHECK: begin
                // The retry count and lock are committed even if the card is pulled now.
                if (!sif.auth_ok) begin
                    tries_d    = w_tries_dec;
                    w_lock_set = (w_tries_dec == 4'd0);
                end
                if (!sif.card_in) begin
                    state_d = S_IDLE;
                end else if (sif.auth_ok) begin
                    timer_d = '0;
                    state_d = S_SESSION;
                end else if (w_tries_dec == 4'd0) begin
                    bp_d    = 1'b1;
                    lk_d    = 1'b1;
                    state_d = S_EJECT;
                end else begin
                    bp_d    = 1'b1;
                    timer_d = '0;
                    state_d = S_WAIT_PIN;
                end
            end
            S_SESSION: begin
                if (!sif.card_in) begin
                    state_d = S_IDLE;
                end else if (sif.logout) begin
                    state_d = S_EJECT;
                end else if (sif.activity) begin
                    timer_d = '0;
                end else if (timer_q == c_SES_LAST) begin
                    to_d    = 1'b1;
                    state_d = S_EJECT;
                end else begin
                    timer_d = timer_q + c_TMR_ONE;
                end
            end
            S_EJECT: begin
                if (!sif.card_in) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if ((state_d == S_IDLE) || (state_d == S_EJECT)) begin
            pin_d = '0;
        end
        active_d   = (state_d == S_SESSION);
        eject_d    = (state_d == S_EJECT);
        sess_idx_d = active_d ? index_q : 4'd0;
    end

    // Lock is applied after unlock so a same-cycle collision leaves the bit set.
    always_comb begin
        lock_d = lock_q;
        for (int i = 0; i < NUM_ACCOUNTS; i++) begin
            if (sif.unlock_req && (sif.unlock_index == 4'(i))) begin
                lock_d[i] = 1'b0;
            end
            if (w_lock_set && (index_q == 4'(i))) begin
                lock_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            timer_q    <= '0;
            index_q    <= '0;
            acc_q      <= '0;
            pin_q      <= '0;
            tries_q    <= c_TRIES;
            sess_idx_q <= '0;
            active_q   <= 1'b0;
            eject_q    <= 1'b0;
            nf_q       <= 1'b0;
            bp_q       <= 1'b0;
            lk_q       <= 1'b0;
            to_q       <= 1'b0;
            lock_q     <= '0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            index_q    <= index_d;
            acc_q      <= acc_d;
            pin_q      <= pin_d;
            tries_q    <= tries_d;
            sess_idx_q <= sess_idx_d;
            active_q   <= active_d;
            eject_q    <= eject_d;
            nf_q       <= nf_d;
            bp_q       <= bp_d;
            lk_q       <= lk_d;
            to_q       <= to_d;
            lock_q     <= lock_d;
        end
    end

    assign sif.auth_acc_num   = acc_q;
    assign sif.auth_pin       = pin_q;
    assign sif.session_active = active_q;
    assign sif.session_index  = sess_idx_q;
    assign sif.tries_left     = tries_q;
    assign sif.eject          = eject_q;
    assign sif.evt_not_found  = nf_q;
    assign sif.evt_bad_pin    = bp_q;
    assign sif.evt_locked     = lk_q;
    assign sif.evt_timeout    = to_q;
    assign sif.state_out      = state_q;

endmodule

`default_nettype wire

// File: tb/tb_atm_session_ctrl.sv
//==============================================================================
// Module      : tb_atm_session_ctrl
// Description : Self-checking bench for atm_session_ctrl with a behavioural
//               authenticator and a session-level lockout model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_atm_session_ctrl;
    localparam int NUM_ACCOUNTS    = 10;
    localparam int MAX_TRIES       = 3;
    localparam int PIN_TIMEOUT     = 1000;
    localparam int SESSION_TIMEOUT = 5000;

    localparam logic [3:0] c_EV_NONE = 4'b0000;
    localparam logic [3:0] c_EV_NF   = 4'b1000;
    localparam logic [3:0] c_EV_BP   = 4'b0100;
    localparam logic [3:0] c_EV_LK   = 4'b0010;
    localparam logic [3:0] c_EV_TO   = 4'b0001;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    atm_session_ctrl_if bus ();

    atm_session_ctrl #(
        .NUM_ACCOUNTS    (NUM_ACCOUNTS),
        .MAX_TRIES       (MAX_TRIES),
        .PIN_TIMEOUT     (PIN_TIMEOUT),
        .SESSION_TIMEOUT (SESSION_TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .sif (bus)
    );

    always #5 clk = ~clk;

    // Account database: accounts 0..8 exist at index = number; 9..15 absent.
    function automatic logic [15:0] pin_of(input logic [3:0] acc);
        return (acc == 4'd5) ? 16'h1234 : (16'hA000 | {12'h000, acc});
    endfunction

    assign bus.auth_found = (bus.auth_acc_num < 4'd9);
    assign bus.auth_index = bus.auth_acc_num;
    assign bus.auth_ok    = bus.auth_found && (bus.auth_pin == pin_of(bus.auth_acc_num));

    function automatic logic [8:0] obs();
        return {bus.state_out, bus.eject, bus.session_active, bus.evt_not_found,
                bus.evt_bad_pin, bus.evt_locked, bus.evt_timeout};
    endfunction

    function automatic logic [8:0] expst(input logic [2:0] s, input logic [3:0] ev);
        return {s, (s == 3'd5), (s == 3'd4), ev};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic insert(input logic [3:0] acc);
        bus.card_in    = 1'b1;
        bus.acc_num_in = acc;
        tick();
    endtask

    task automatic enter_pin(input logic [15:0] p);
        bus.pin_valid = 1'b1;
        bus.pin_in    = p;
        tick();
        bus.pin_valid = 1'b0;
    endtask

    task automatic remove_card();
        bus.card_in = 1'b0;
        tick();
    endtask

    task automatic pulse_unlock(input logic [3:0] idx);
        bus.unlock_req   = 1'b1;
        bus.unlock_index = idx;
        tick();
        bus.unlock_req   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        tick();
        checks++;
        if (obs() !== expst(3'd0, c_EV_NONE)) begin
            errors++; $display("FAIL reset_status: got %h expected %h", obs(), expst(3'd0, c_EV_NONE));
        end
        checks++;
        if (bus.tries_left !== 4'd3) begin
            errors++; $display("FAIL reset_tries: got %0d expected 3", bus.tries_left);
        end
        checks++;
        if ({bus.auth_acc_num, bus.auth_pin, bus.session_index} !== 24'h0) begin
            errors++; $display("FAIL reset_regs: got %h expected 0", {bus.auth_acc_num, bus.auth_pin, bus.session_index});
        end
        rst = 1'b1;
    endtask

    task automatic test_good_session();
        insert(4'd5);
        checks++;
        if (obs() !== expst(3'd1, c_EV_NONE) || bus.auth_acc_num !== 4'd5) begin
            errors++; $display("FAIL good_lookup: got %h/%0d expected %h/5", obs(), bus.auth_acc_num, expst(3'd1, c_EV_NONE));
        end
        tick();
        checks++;
        if (obs() !== expst(3'd2, c_EV_NONE) || bus.tries_left !== 4'd3) begin
            errors++; $display("FAIL good_waitpin: got %h/%0d expected %h/3", obs(), bus.tries_left, expst(3'd2, c_EV_NONE));
        end
        enter_pin(16'h1234);
        checks++;
        if (obs() !== expst(3'd3, c_EV_NONE) || bus.auth_pin !== 16'h1234) begin
            errors++; $display("FAIL good_check: got %h/%h expected %h/1234", obs(), bus.auth_pin, expst(3'd3, c_EV_NONE));
        end
        tick();
        checks++;
        if (obs() !== expst(3'd4, c_EV_NONE) || bus.session_index !== 4'd5) begin
            errors++; $display("FAIL good_session: got %h/%0d expected %h/5", obs(), bus.session_index, expst(3'd4, c_EV_NONE));
        end
        bus.logout = 1'b1;
        tick();
        bus.logout = 1'b0;
        checks++;
        if (obs() !== expst(3'd5, c_EV_NONE) || bus.session_index !== 4'd0 || bus.auth_pin !== 16'h0) begin
            errors++; $display("FAIL good_eject: got %h/%0d/%h expected %h/0/0", obs(), bus.session_index, bus.auth_pin, expst(3'd5, c_EV_NONE));
        end
        remove_card();
        checks++;
        if (obs() !== expst(3'd0, c_EV_NONE)) begin
            errors++; $display("FAIL good_idle: got %h expected %h", obs(), expst(3'd0, c_EV_NONE));
        end
    endtask

    task automatic test_not_found();
        insert(4'd9);
        tick();
        checks++;
        if (obs() !== expst(3'd5, c_EV_NF) || bus.auth_pin !== 16'h0) begin
            errors++; $display("FAIL nf_pulse: got %h/%h expected %h/0", obs(), bus.auth_pin, expst(3'd5, c_EV_NF));
        end
        tick();
        checks++;
        if (obs() !== expst(3'd5, c_EV_NONE)) begin
            errors++; $display("FAIL nf_hold: got %h expected %h", obs(), expst(3'd5, c_EV_NONE));
        end
        remove_card();
        checks++;
        if (obs() !== expst(3'd0, c_EV_NONE)) begin
            errors++; $display("FAIL nf_idle: got %h expected %h", obs(), expst(3'd0, c_EV_NONE));
        end
    endtask

    task automatic test_lockout();
        insert(4'd3);
        tick();
        for (int k = 1; k <= MAX_TRIES; k++) begin
            enter_pin(16'hBEEF);
            tick();
            checks++;
            if (k < MAX_TRIES) begin
                if (obs() !== expst(3'd2, c_EV_BP) || bus.tries_left !== 4'(MAX_TRIES - k)) begin
                    errors++; $display("FAIL lock_try%0d: got %h/%0d expected %h/%0d", k, obs(), bus.tries_left, expst(3'd2, c_EV_BP), MAX_TRIES - k);
                end
            end else begin
                if (obs() !== expst(3'd5, c_EV_BP | c_EV_LK) || bus.tries_left !== 4'd0) begin
                    errors++; $display("FAIL lock_final: got %h/%0d expected %h/0", obs(), bus.tries_left, expst(3'd5, c_EV_BP | c_EV_LK));
                end
            end
        end
        remove_card();
        insert(4'd3);
        tick();
        checks++;
        if (obs() !== expst(3'd5, c_EV_LK)) begin
            errors++; $display("FAIL lock_reinsert: got %h expected %h", obs(), expst(3'd5, c_EV_LK));
        end
        remove_card();
        pulse_unlock(4'd3);
        checks++;
        if (obs() !== expst(3'd0, c_EV_NONE)) begin
            errors++; $display("FAIL unlock_state: got %h expected %h", obs(), expst(3'd0, c_EV_NONE));
        end
        insert(4'd3);
        tick();
        enter_pin(pin_of(4'd3));
        tick();
        checks++;
        if (obs() !== expst(3'd4, c_EV_NONE) || bus.session_index !== 4'd3) begin
            errors++; $display("FAIL unlock_session: got %h/%0d expected %h/3", obs(), bus.session_index, expst(3'd4, c_EV_NONE));
        end
        bus.logout = 1'b1;
        tick();
        bus.logout = 1'b0;
        remove_card();
    endtask

    task automatic test_pin_timeout();
        insert(4'd1);
        tick();
        repeat (PIN_TIMEOUT - 1) tick();
        checks++;
        if (obs() !== expst(3'd2, c_EV_NONE)) begin
            errors++; $display("FAIL pin_to_early: got %h expected %h", obs(), expst(3'd2, c_EV_NONE));
        end
        tick();
        checks++;
        if (obs() !== expst(3'd5, c_EV_TO)) begin
            errors++; $display("FAIL pin_to_fire: got %h expected %h", obs(), expst(3'd5, c_EV_TO));
        end
        remove_card();
        insert(4'd1);
        tick();
        repeat (PIN_TIMEOUT - 1) tick();
        enter_pin(pin_of(4'd1));
        checks++;
        if (obs() !== expst(3'd3, c_EV_NONE)) begin
            errors++; $display("FAIL pin_last_cycle: got %h expected %h", obs(), expst(3'd3, c_EV_NONE));
        end
        tick();
        bus.logout = 1'b1;
        tick();
        bus.logout = 1'b0;
        remove_card();
    endtask

    task automatic test_session_timeout();
        insert(4'd5);
        tick();
        enter_pin(16'h1234);
        tick();
        repeat (2) begin
            repeat (4000 - 1) tick();
            bus.activity = 1'b1;
            tick();
            bus.activity = 1'b0;
            checks++;
            if (obs() !== expst(3'd4, c_EV_NONE)) begin
                errors++; $display("FAIL ses_activity: got %h expected %h", obs(), expst(3'd4, c_EV_NONE));
            end
        end
        repeat (SESSION_TIMEOUT - 1) tick();
        checks++;
        if (obs() !== expst(3'd4, c_EV_NONE)) begin
            errors++; $display("FAIL ses_to_early: got %h expected %h", obs(), expst(3'd4, c_EV_NONE));
        end
        tick();
        checks++;
        if (obs() !== expst(3'd5, c_EV_TO)) begin
            errors++; $display("FAIL ses_to_fire: got %h expected %h", obs(), expst(3'd5, c_EV_TO));
        end
        remove_card();
        insert(4'd5);
        tick();
        enter_pin(16'h1234);
        tick();
        bus.logout   = 1'b1;
        bus.activity = 1'b1;
        tick();
        bus.logout   = 1'b0;
        bus.activity = 1'b0;
        checks++;
        if (obs() !== expst(3'd5, c_EV_NONE)) begin
            errors++; $display("FAIL logout_vs_act: got %h expected %h", obs(), expst(3'd5, c_EV_NONE));
        end
        remove_card();
    endtask

    task automatic test_reset_midsession();
        insert(4'd4);
        tick();
        repeat (MAX_TRIES) begin
            enter_pin(16'h0BAD);
            tick();
        end
        remove_card();
        insert(4'd2);
        tick();
        enter_pin(16'h0BAD);
        tick();
        checks++;
        if (obs() !== expst(3'd2, c_EV_BP) || bus.tries_left !== 4'd2) begin
            errors++; $display("FAIL rstm_pre: got %h/%0d expected %h/2", obs(), bus.tries_left, expst(3'd2, c_EV_BP));
        end
        rst         = 1'b0;
        bus.card_in = 1'b0;
        tick();
        rst = 1'b1;
        checks++;
        if (obs() !== expst(3'd0, c_EV_NONE) || bus.tries_left !== 4'd3) begin
            errors++; $display("FAIL rstm_post: got %h/%0d expected %h/3", obs(), bus.tries_left, expst(3'd0, c_EV_NONE));
        end
        insert(4'd4);
        tick();
        checks++;
        if (obs() !== expst(3'd2, c_EV_NONE)) begin
            errors++; $display("FAIL rstm_lock_clr: got %h expected %h", obs(), expst(3'd2, c_EV_NONE));
        end
        remove_card();
    endtask

    task automatic test_card_pull_and_unlock();
        insert(4'd6);
        tick();
        repeat (MAX_TRIES - 1) begin
            enter_pin(16'h0BAD);
            tick();
        end
        enter_pin(16'h0BAD);
        bus.card_in = 1'b0;
        tick();
        checks++;
        if (obs() !== expst(3'd0, c_EV_NONE) || bus.auth_pin !== 16'h0) begin
            errors++; $display("FAIL pull_check: got %h/%h expected %h/0", obs(), bus.auth_pin, expst(3'd0, c_EV_NONE));
        end
        pulse_unlock(4'd14);
        insert(4'd6);
        tick();
        checks++;
        if (obs() !== expst(3'd5, c_EV_LK)) begin
            errors++; $display("FAIL pull_locked: got %h expected %h", obs(), expst(3'd5, c_EV_LK));
        end
        remove_card();
        insert(4'd7);
        tick();
        repeat (MAX_TRIES - 1) begin
            enter_pin(16'h0BAD);
            tick();
        end
        enter_pin(16'h0BAD);
        bus.unlock_req   = 1'b1;
        bus.unlock_index = 4'd7;
        tick();
        bus.unlock_req   = 1'b0;
        remove_card();
        insert(4'd7);
        tick();
        checks++;
        if (obs() !== expst(3'd5, c_EV_LK)) begin
            errors++; $display("FAIL lock_beats_unlock: got %h expected %h", obs(), expst(3'd5, c_EV_LK));
        end
        remove_card();
    endtask

    task automatic test_random();
        bit          mlock [NUM_ACCOUNTS];
        logic [3:0]  acc;
        logic [3:0]  uidx;
        logic [15:0] p;
        int          tries;
        bit          good;
        bit          done;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        foreach (mlock[i]) mlock[i] = 1'b0;
        for (int it = 0; it < 60; it++) begin
            if ($urandom_range(0, 2) == 0) begin
                uidx = 4'($urandom_range(0, 15));
                pulse_unlock(uidx);
                if (uidx < 4'(NUM_ACCOUNTS)) mlock[uidx] = 1'b0;
            end
            acc = 4'($urandom_range(0, 9));
            insert(acc);
            tick();
            checks++;
            if (acc == 4'd9) begin
                if (obs() !== expst(3'd5, c_EV_NF)) begin
                    errors++; $display("FAIL rnd_nf it%0d: got %h expected %h", it, obs(), expst(3'd5, c_EV_NF));
                end
            end else if (mlock[acc]) begin
                if (obs() !== expst(3'd5, c_EV_LK)) begin
                    errors++; $display("FAIL rnd_locked it%0d acc%0d: got %h expected %h", it, acc, obs(), expst(3'd5, c_EV_LK));
                end
            end else begin
                if (obs() !== expst(3'd2, c_EV_NONE)) begin
                    errors++; $display("FAIL rnd_lookup it%0d acc%0d: got %h expected %h", it, acc, obs(), expst(3'd2, c_EV_NONE));
                end
                tries = MAX_TRIES;
                done  = 1'b0;
                while (!done) begin
                    good = ($urandom_range(0, 2) == 0);
                    p    = good ? pin_of(acc) : (pin_of(acc) ^ 16'($urandom_range(1, 65535)));
                    enter_pin(p);
                    tick();
                    checks++;
                    if (good) begin
                        done = 1'b1;
                        if (obs() !== expst(3'd4, c_EV_NONE) || bus.session_index !== acc) begin
                            errors++; $display("FAIL rnd_session it%0d: got %h/%0d expected %h/%0d", it, obs(), bus.session_index, expst(3'd4, c_EV_NONE), acc);
                        end
                        bus.logout = 1'b1;
                        tick();
                        bus.logout = 1'b0;
                    end else begin
                        tries--;
                        if (tries == 0) begin
                            done       = 1'b1;
                            mlock[acc] = 1'b1;
                            if (obs() !== expst(3'd5, c_EV_BP | c_EV_LK)) begin
                                errors++; $display("FAIL rnd_lockout it%0d: got %h expected %h", it, obs(), expst(3'd5, c_EV_BP | c_EV_LK));
                            end
                        end else if (obs() !== expst(3'd2, c_EV_BP) || bus.tries_left !== 4'(tries)) begin
                            errors++; $display("FAIL rnd_badpin it%0d: got %h/%0d expected %h/%0d", it, obs(), bus.tries_left, expst(3'd2, c_EV_BP), tries);
                        end
                    end
                end
            end
            remove_card();
            checks++;
            if (obs() !== expst(3'd0, c_EV_NONE)) begin
                errors++; $display("FAIL rnd_idle it%0d: got %h expected %h", it, obs(), expst(3'd0, c_EV_NONE));
            end
        end
    endtask

    initial begin
        rst              = 1'b0;
        bus.card_in      = 1'b0;
        bus.acc_num_in   = 4'd0;
        bus.pin_valid    = 1'b0;
        bus.pin_in       = 16'h0;
        bus.logout       = 1'b0;
        bus.activity     = 1'b0;
        bus.unlock_req   = 1'b0;
        bus.unlock_index = 4'd0;
        test_reset();
        test_good_session();
        test_not_found();
        test_lockout();
        test_pin_timeout();
        test_session_timeout();
        test_reset_midsession();
        test_card_pull_and_unlock();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/atm_session_ctrl.md
Name: atm_session_ctrl

Overview:
- Sequencing controller that wraps the combinational account authenticator and owns one customer session from card insertion to ejection.
- Registers the account number and PIN into the authenticator, then samples its found/authenticated status one cycle later.
- Enforces a PIN retry limit with a per-account lockout table, a PIN-entry timeout and a session-idle timeout.
- Hands an authenticated account index to the transaction logic.

Parameters:
- NUM_ACCOUNTS, 10: number of account slots; sets the lockout table size.
- MAX_TRIES, 3: wrong-PIN attempts allowed before the account is locked (1..15).
- PIN_TIMEOUT, 1000: cycles allowed in WAIT_PIN before abort.
- SESSION_TIMEOUT, 5000: idle cycles allowed in SESSION before forced logout.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-low reset
- card_in  in  1  card present level
- acc_num_in  in  4  account number read from card; sampled on card accept
- pin_valid  in  1  one-cycle strobe; pin_in is valid
- pin_in  in  16  entered PIN
- logout  in  1  customer ends session
- activity  in  1  transaction activity; restarts the session idle timer
- unlock_req  in  1  admin strobe: clear lock bit unlock_index
- unlock_index  in  4  account index to unlock
- auth_found  in  1  authenticator found status (`ACCOUNT_FOUND = 1)
- auth_ok  in  1  authenticator auth status (`ACCOUNT_AUTHENTICATED = 1)
- auth_index  in  4  authenticator account index
- auth_acc_num  out  4  registered account number to authenticator
- auth_pin  out  16  registered PIN to authenticator
- session_active  out  1  high only in SESSION
- session_index  out  4  authenticated account index; valid while session_active
- tries_left  out  4  remaining PIN attempts
- eject  out  1  high in EJECT
- evt_not_found, evt_bad_pin, evt_locked, evt_timeout  out  1 each  one-cycle event pulses
- state_out  out  3  current state encoding

Behaviour:
- Reset (rst = 0 at a clk edge):
  - state = IDLE; every output 0 except tries_left = MAX_TRIES.
  - The whole lock table is cleared.
  - Reset mid-session aborts the session with no event pulse.
- State encoding: IDLE = 0, LOOKUP = 1, WAIT_PIN = 2, CHECK = 3, SESSION = 4, EJECT = 5.
- IDLE:
  - When card_in = 1: latch acc_num_in into auth_acc_num, clear auth_pin to 0, set tries_left = MAX_TRIES, go to LOOKUP.
- LOOKUP (exactly 1 cycle; authenticator inputs are stable, so its outputs are valid):
  - auth_found = 0: pulse evt_not_found, go to EJECT.
  - Found and lock[auth_index] = 1: pulse evt_locked, go to EJECT.
  - Otherwise: latch auth_index into an internal index register, clear the timer, go to WAIT_PIN.
- WAIT_PIN:
  - The timer increments every cycle.
  - pin_valid = 1: latch pin_in into auth_pin, go to CHECK. pin_valid has priority over timeout in the same cycle.
  - Timer == PIN_TIMEOUT-1 with no pin_valid: pulse evt_timeout, go to EJECT. Exactly PIN_TIMEOUT cycles are spent in WAIT_PIN.
- CHECK (1 cycle):
  - auth_ok = 1: session_index = index register, clear the timer, go to SESSION.
  - Otherwise, with tries_left decremented by one:
    - Result > 0: pulse evt_bad_pin, clear the timer, return to WAIT_PIN.
    - Result = 0: set lock[index] = 1, pulse evt_bad_pin and evt_locked in the same cycle, go to EJECT.
- SESSION:
  - logout = 1: go to EJECT. logout beats activity in the same cycle.
  - activity = 1: clear the timer.
  - Timer == SESSION_TIMEOUT-1 with no activity: pulse evt_timeout, go to EJECT.
- EJECT:
  - eject = 1; auth_pin cleared to 0; session_index cleared.
  - Go to IDLE when card_in = 0.
- Card removal (card_in = 0) in LOOKUP, WAIT_PIN, CHECK or SESSION: go directly to IDLE, clear auth_pin, no event pulse.
  - A lock decision made in that same CHECK cycle is still committed.
- Unlock:
  - Honoured in any state; unlock_index >= NUM_ACCOUNTS is ignored.
  - If an unlock and a lock target the same index in the same cycle, the lock wins.
  - Unlocking never changes the current state.
- Lock table:
  - NUM_ACCOUNTS bits; read combinationally in LOOKUP using auth_index.
  - Persists across sessions; cleared only by reset or unlock.
- All outputs are registered; event pulses are high for exactly one cycle, on the cycle after the deciding state.

Test Plan:
- Account 5, correct PIN 0x1234 on first try -> LOOKUP 1 cycle, CHECK 1 cycle, session_active = 1 with session_index = 5; logout -> EJECT; card_in = 0 -> IDLE.
- Account 9 absent from the database -> evt_not_found pulse, eject = 1, state_out = 5 until card_in drops; auth_pin never loaded.
- Account 3, three wrong PINs (MAX_TRIES = 3) -> tries_left 3→2→1→0, evt_bad_pin ×3, evt_locked on the third, eject; reinsert account 3 -> evt_locked from LOOKUP; unlock_req with index 3, then correct PIN -> SESSION.
- No PIN for 1000 cycles (PIN_TIMEOUT = 1000) -> evt_timeout exactly 1000 cycles after WAIT_PIN entry; pin_valid on cycle 1000 instead -> CHECK, no timeout.
- In SESSION, activity every 4000 cycles -> no timeout; then idle 5000 cycles -> evt_timeout, eject. logout and activity together -> EJECT.
- rst = 0 during WAIT_PIN after one wrong PIN -> IDLE, tries_left = 3, lock table cleared, all pulses 0. Card pulled in CHECK on the final wrong PIN -> IDLE and account locked.
